// File: rtl/rf_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_queue
//  Purpose  : In-order write queue in front of the register file write port.
//             Accepts ALU and MDU results over valid/ready, buffers them in a
//             small circular FIFO and retires at most one write per cycle.
//             Also reports whether a decode read address has a write pending
//             so decode can stall on RAW hazards.
//  Ports    : clk, rst_n                 - clock, synchronous active-low reset
//             mdu_valid/ready/waddr/wdata - MDU result handshake (has priority)
//             alu_valid/ready/waddr/wdata - ALU result handshake
//             rf_we/rf_waddr/rf_wdata     - registered register file write port
//             raddr1/raddr2 -> busy1/busy2 - pending-write hazard lookup
//             count                       - entries currently queued
//  Revision : 1.0 - initial release
// ============================================================================
module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mdu_valid,
  output logic                         mdu_ready,
  input  logic [AW-1:0]                mdu_waddr,
  input  logic [DW-1:0]                mdu_wdata,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [AW-1:0]                alu_waddr,
  input  logic [DW-1:0]                alu_wdata,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  input  logic [AW-1:0]                raddr1,
  input  logic [AW-1:0]                raddr2,
  output logic                         busy1,
  output logic                         busy2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Occupancy limits at which one / two free slots still exist.
  localparam logic [CW-1:0] c_room1_max = CW'(DEPTH-1);
  localparam logic [CW-1:0] c_room2_max = CW'(DEPTH-2);

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [AW-1:0] mem_addr_d [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];
  logic [DW-1:0] mem_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic          mdu_push, alu_push, pop;
  logic [PW-1:0] alu_slot;
  logic [PW-1:0] idx;
  logic          hit1, hit2;

  // Readiness only looks at current occupancy; a same-cycle pop is not
  // credited so there is no combinational path from drain to ready.
  always_comb begin
    mdu_ready = rst_n && (count_q <= c_room1_max);
    alu_ready = rst_n && (mdu_valid ? (count_q <= c_room2_max)
                                    : (count_q <= c_room1_max));
    // Writes to x0 complete the handshake but never occupy a slot.
    mdu_push  = mdu_valid && mdu_ready && (mdu_waddr != '0);
    alu_push  = alu_valid && alu_ready && (alu_waddr != '0);
    pop       = (count_q != '0);
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rd_ptr_d   = rd_ptr_q;
    rf_we_d    = pop;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_waddr_d = mem_addr_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PW'(1);
    end
    // MDU goes first; ALU lands in the slot behind it when both push.
    alu_slot = mdu_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    if (mdu_push) begin
      mem_addr_d[wr_ptr_q] = mdu_waddr;
      mem_data_d[wr_ptr_q] = mdu_wdata;
    end
    if (alu_push) begin
      mem_addr_d[alu_slot] = alu_waddr;
      mem_data_d[alu_slot] = alu_wdata;
    end
    wr_ptr_d = wr_ptr_q + PW'(mdu_push) + PW'(alu_push);
    count_d  = count_q + CW'(mdu_push) + CW'(alu_push) - CW'(pop);
  end

  // Hazard lookup over the live entries plus the write currently on the port.
  always_comb begin
    hit1 = rf_we_q && (rf_waddr_q == raddr1);
    hit2 = rf_we_q && (rf_waddr_q == raddr2);
    idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_addr_q[idx] == raddr1) hit1 = 1'b1;
        if (mem_addr_q[idx] == raddr2) hit2 = 1'b1;
      end
    end
    busy1 = (raddr1 != '0) && hit1;
    busy2 = (raddr2 != '0) && hit2;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr_q <= '{default: '0};
      mem_data_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign count    = count_q;

endmodule
`default_nettype wire
